// File: rtl/systolic_feeder_pkg.sv
// Shared types for the systolic operand feeder.
//   word_t         : raw operand word; passed through bit-exact, never interpreted
//   feeder_state_t : feeder FSM states
package systolic_feeder_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    StFill,
    StIssue,
    StFlush,
    StDrain,
    StDone
  } feeder_state_t;

  // Counter width that can hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Upstream operand stream into the feeder (valid/ready, one x/w vector pair per beat).
//   in_valid : producer has a vector pair on in_x/in_w
//   in_ready : feeder accepts the pair on this edge
//   in_x     : N-lane x operand vector
//   in_w     : N-lane w operand vector
// master = producer (tile loader / bench), slave = feeder.
interface systolic_feeder_if #(
  parameter int unsigned N = 4
) ();
  import systolic_feeder_pkg::*;

  logic            in_valid;
  logic            in_ready;
  word_t [N-1:0]   in_x;
  word_t [N-1:0]   in_w;

  modport master (
    output in_valid,
    output in_x,
    output in_w,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_x,
    input  in_w,
    output in_ready
  );

endinterface

// File: rtl/systolic_feeder_buf.sv
// feeder_buf: tile operand buffer, Depth entries of {x vector, w vector}.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write index
//   wx_i    : x vector to store
//   ww_i    : w vector to store
//   raddr_i : asynchronous read index
//   rx_o    : x vector at raddr_i
//   rw_o    : w vector at raddr_i
// No reset: the feeder's counters decide which entries are meaningful.
module feeder_buf
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = idx_width(Depth)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AddrW-1:0]      waddr_i,
  input  word_t [N-1:0]         wx_i,
  input  word_t [N-1:0]         ww_i,
  input  logic [AddrW-1:0]      raddr_i,
  output word_t [N-1:0]         rx_o,
  output word_t [N-1:0]         rw_o
);

  word_t [N-1:0] mem_x_q [Depth];
  word_t [N-1:0] mem_w_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_x_q[waddr_i] <= wx_i;
      mem_w_q[waddr_i] <= ww_i;
    end
  end

  assign rx_o = mem_x_q[raddr_i];
  assign rw_o = mem_w_q[raddr_i];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one tile of LOAD_CYCLES x/w vector pairs from an upstream stream,
// then streams them into systolic_array (start/x_in/w_in, honouring stall), follows with N-1
// zero vectors to flush the array, waits in DRAIN for stall to clear and pulses done.
//   clk          : clock
//   rst          : synchronous active-high reset; aborts any tile in progress
//   up           : upstream operand stream (systolic_feeder_if.slave)
//   stall        : array did not consume the presented vector this cycle
//   start        : operands valid to the array; high from ISSUE entry through DRAIN
//   x_in, w_in   : operand vectors to the array (zero in FLUSH/DRAIN and when idle)
//   done         : one-cycle pulse after the tile is fully processed
//   stall_cycles : stalled cycles of the current/last tile, saturating
//                  (only when FEEDER_STALL_CNT_EN is defined)
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned LOAD_CYCLES = 2 * N
) (
  input  logic                clk,
  input  logic                rst,
  systolic_feeder_if.slave    up,
  input  logic                stall,
  output logic                start,
  output word_t [N-1:0]       x_in,
  output word_t [N-1:0]       w_in,
  output logic                done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int unsigned CntW = $clog2(LOAD_CYCLES + 1);
  localparam int unsigned IdxW = idx_width(LOAD_CYCLES);
  localparam int unsigned FlW  = idx_width(N);

  localparam logic [CntW-1:0] LoadMax   = CntW'(LOAD_CYCLES);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(LOAD_CYCLES - 1);
  localparam logic [FlW-1:0]  FlushLast = FlW'((N > 1) ? N - 2 : 0);

  feeder_state_t   state_q, state_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [IdxW-1:0] rd_cnt_q, rd_cnt_d;
  logic [FlW-1:0]  flush_cnt_q, flush_cnt_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  word_t [N-1:0]   x_q, x_d;
  word_t [N-1:0]   w_q, w_d;

  logic            accept;
  logic            consume;
  logic [IdxW-1:0] rd_addr;
  word_t [N-1:0]   rd_x, rd_w;

  assign up.in_ready = !rst && (state_q == StFill) && (wr_cnt_q < LoadMax);
  assign accept      = up.in_valid && up.in_ready;
  assign consume     = start_q && !stall;

  // Read ahead: in ISSUE the buffer presents the vector to load on the next consume.
  // On the last vector the address is parked at 0 since zeros are loaded instead.
  always_comb begin
    rd_addr = '0;
    if (state_q == StIssue && rd_cnt_q != LastIdx) begin
      rd_addr = rd_cnt_q + IdxW'(1);
    end
  end

  feeder_buf #(
    .N     (N),
    .Depth (LOAD_CYCLES)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (accept),
    .waddr_i (wr_cnt_q[IdxW-1:0]),
    .wx_i    (up.in_x),
    .ww_i    (up.in_w),
    .raddr_i (rd_addr),
    .rx_o    (rd_x),
    .rw_o    (rd_w)
  );

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    flush_cnt_d = flush_cnt_q;
    start_d     = start_q;
    done_d      = 1'b0;
    x_d         = x_q;
    w_d         = w_q;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          wr_cnt_d = wr_cnt_q + CntW'(1);
        end else if (wr_cnt_q == LoadMax) begin
          state_d  = StIssue;
          start_d  = 1'b1;
          rd_cnt_d = '0;
          x_d      = rd_x;
          w_d      = rd_w;
        end
      end
      StIssue: begin
        if (consume) begin
          if (rd_cnt_q == LastIdx) begin
            x_d         = '0;
            w_d         = '0;
            flush_cnt_d = '0;
            state_d     = (N > 1) ? StFlush : StDrain;
          end else begin
            rd_cnt_d = rd_cnt_q + IdxW'(1);
            x_d      = rd_x;
            w_d      = rd_w;
          end
        end
      end
      StFlush: begin
        if (consume) begin
          if (flush_cnt_q == FlushLast) begin
            state_d = StDrain;
          end else begin
            flush_cnt_d = flush_cnt_q + FlW'(1);
          end
        end
      end
      StDrain: begin
        if (consume) begin
          state_d = StDone;
          start_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d     = StFill;
        wr_cnt_d    = '0;
        rd_cnt_d    = '0;
        flush_cnt_d = '0;
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      flush_cnt_q <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      start_q     <= start_d;
      done_q      <= done_d;
      x_q         <= x_d;
      w_q         <= w_d;
    end
  end

  assign start = start_q;
  assign done  = done_q;
  assign x_in  = x_q;
  assign w_in  = w_q;

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // FILL->ISSUE happens with start low, so clearing never collides with counting.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == StFill && state_d == StIssue) begin
      stall_cnt_d = '0;
    end else if (start_q && stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder (N=4, LOAD_CYCLES=8). Stimulus pushes the expected operand
// sequence of each tile into a queue; a negedge monitor compares every start=1 cycle against
// the queue head and pops it on consume. Build with FEEDER_STALL_CNT_EN to also check
// stall_cycles.
module tb_systolic_feeder;
  import systolic_feeder_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned LC = 2 * N;

  typedef struct packed {
    word_t [N-1:0] x;
    word_t [N-1:0] w;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          start;
  logic          done;
  word_t [N-1:0] x_in;
  word_t [N-1:0] w_in;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  systolic_feeder_if #(.N(N)) up ();

  systolic_feeder #(
    .N           (N),
    .LOAD_CYCLES (LC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .up    (up),
    .stall (stall),
    .start (start),
    .x_in  (x_in),
    .w_in  (w_in),
    .done  (done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  vec_t  exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    done_cnt   = 0;
  logic  done_prev  = 1'b0;
  vec_t  tile [LC];
  word_t fval [LC] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                       32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Operand monitor: compare presented vectors, and zero operands whenever start is low.
  always @(negedge clk) begin
    if (start) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL operand_unexpected: got x_in=%h w_in=%h expected no vector", x_in, w_in);
      end else begin
        if ({x_in, w_in} !== {exp_q[0].x, exp_q[0].w}) begin
          mismatched++;
          $display("FAIL operand: got x_in=%h w_in=%h expected x_in=%h w_in=%h",
                   x_in, w_in, exp_q[0].x, exp_q[0].w);
        end
        if (!stall) void'(exp_q.pop_front());
      end
    end else if (!rst) begin
      check("idle_operands_zero", {x_in[0], w_in[0]} | 64'(|{x_in, w_in}), 64'd0);
    end
  end

  // done must be a single-cycle pulse.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_single_cycle", done_prev, 1'b0);
    end
    done_prev <= done;
  end

  task automatic load_tile(input int kind);
    for (int k = 0; k < LC; k++) begin
      for (int j = 0; j < N; j++) begin
        unique case (kind)
          0: begin
            tile[k].x[j] = fval[k];
            tile[k].w[j] = 32'h4000_0000;
          end
          1: begin
            tile[k].x[j] = 32'h1000_0000 + 32'(k) * 32'h100 + 32'(j);
            tile[k].w[j] = 32'h8000_0000 + 32'(j) * 32'h10 + 32'(k);
          end
          default: begin
            tile[k].x[j] = 32'hDEAD_0000 ^ (32'(k) << 4 | 32'(j));
            tile[k].w[j] = 32'h0BAD_F000 ^ (32'(j) << 8 | 32'(k));
          end
        endcase
      end
    end
  endtask

  // Offer one vector; returns after the accepting edge (at posedge+1).
  task automatic send(input vec_t v, output int waits);
    logic rdy;
    waits = 0;
    up.in_valid = 1'b1;
    up.in_x     = v.x;
    up.in_w     = v.w;
    forever begin
      @(negedge clk);
      rdy = up.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 50) begin
        fail_now("send_accept");
        break;
      end
    end
    up.in_valid = 1'b0;
  endtask

  task automatic send_tile(input bit gaps, output int first_wait);
    int w;
    first_wait = 0;
    for (int k = 0; k < LC; k++) begin
      if (gaps && k > 0) begin
        up.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      exp_q.push_back(tile[k]);
      send(tile[k], w);
      if (k == 0) first_wait = w;
    end
    // N-1 flush zeros plus the DRAIN cycle's zero vector.
    for (int z = 0; z < N; z++) exp_q.push_back('0);
  endtask

  // Drive stall by start-cycle index, check done timing; optional reset at a start cycle.
  task automatic run_tile(input logic [31:0] mask, input int exp_done, input int rst_at);
    int i = 0;
    bit seen = 0;
    stall = mask[0];
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (start) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      fail_now("start_rise");
    end else begin
      forever begin
        @(posedge clk);
        #1;
        i++;
        stall = (i < 32) ? mask[i] : 1'b0;
        if (i == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          check("in_ready_in_reset", up.in_ready, 1'b0);
          @(posedge clk);
          #1;
          rst   = 1'b0;
          stall = 1'b0;
          @(negedge clk);
          check("abort_start", start, 1'b0);
          check("abort_x_in", x_in, 64'd0);
          check("abort_done", done, 1'b0);
          exp_q.delete();
          repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
          end
          break;
        end
        @(negedge clk);
        if (done) begin
          check("done_cycle", i, exp_done);
          check("start_in_done", start, 1'b0);
          check("queue_drained", exp_q.size(), 0);
          break;
        end
        if (i > 60) begin
          fail_now("done_wait");
          break;
        end
      end
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    up.in_valid = 1'b0;
    up.in_x     = '0;
    up.in_w     = '0;

    // Reset
    repeat (2) begin
      @(negedge clk);
      check("in_ready_in_reset", up.in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_start", start, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_in_ready", up.in_ready, 1'b1);
`ifdef FEEDER_STALL_CNT_EN
    check("reset_stall_cycles", stall_cycles, 0);
`endif
    @(posedge clk);
    #1;

    // Stall-free float tile
    load_tile(0);
    send_tile(1'b0, w);
    run_tile(32'h0, 12, -1);
`ifdef FEEDER_STALL_CNT_EN
    check("stall_cycles_free", stall_cycles, 0);
`endif

    // Stall: 3 cycles on vector 2, 2 cycles in FLUSH
    load_tile(0);
    send_tile(1'b0, w);
    run_tile(32'h0000_301C, 17, -1);
`ifdef FEEDER_STALL_CNT_EN
    check("stall_cycles_five", stall_cycles, 5);
`endif

    // Upstream backpressure, stall high while idle/filling must be ignored
    load_tile(1);
    stall = 1'b1;
    send_tile(1'b1, w);
    up.in_valid = 1'b1;
    up.in_x     = {N{32'hBAD0_BAD0}};
    up.in_w     = {N{32'hBAD1_BAD1}};
    @(negedge clk);
    check("in_ready_after_full", up.in_ready, 1'b0);
    @(posedge clk);
    #1;
    up.in_valid = 1'b0;
    run_tile(32'h0, 12, -1);
`ifdef FEEDER_STALL_CNT_EN
    check("stall_cycles_idle_ignored", stall_cycles, 0);
`endif

    // Reset during vector 3, then a fresh tile
    load_tile(2);
    send_tile(1'b0, w);
    run_tile(32'h0, 0, 3);
    load_tile(1);
    send_tile(1'b0, w);
    run_tile(32'h0, 12, -1);

    // Back-to-back tiles
    load_tile(2);
    send_tile(1'b0, w);
    run_tile(32'h0, 12, -1);
    load_tile(0);
    send_tile(1'b0, w);
    check("b2b_first_accept_wait", w, 0);
    run_tile(32'h0, 12, -1);

    // DRAIN hold: stall through 6 cycles after the last flush consume
    load_tile(1);
    send_tile(1'b0, w);
    run_tile(32'h0001_F800, 18, -1);
`ifdef FEEDER_STALL_CNT_EN
    check("stall_cycles_drain", stall_cycles, 6);
`endif

    repeat (2) @(posedge clk);
    check("done_pulses", done_cnt, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
